// File: rtl/palette_ctrl.sv
// DAC-style palette write controller: index/R/G/B byte writes are packed into
// entries, buffered, and committed to the palette RAM only during blanking.
// Optional macro PALETTE_CTRL_ANYTIME_EN drains the buffer regardless of blank.
module palette_ctrl #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk_pix,
  input  logic          rst_pix,
  input  logic          reg_valid,
  output logic          reg_ready,
  input  logic          reg_addr,
  input  logic [7:0]    reg_wdata,
  input  logic          blank,
  output logic          pal_we,
  output logic [7:0]    pal_addr,
  output logic [23:0]   pal_wdata,
  output logic [AW:0]   fifo_level,
  output logic          busy
);

  typedef enum logic [1:0] {PhR, PhG, PhB} phase_e;

  phase_e phase_q, phase_d;

  logic [7:0]    index_q;
  logic [7:0]    r_q, g_q;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          pal_we_q;
  logic [7:0]    pal_addr_q;
  logic [23:0]   pal_wdata_q;
  logic          busy_q;

  logic accept, fifo_full, fifo_empty, push, pop, ld_r, ld_g, ld_index;
  logic [31:0] head;

  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Uses the registered full flag, so a same-cycle pop never frees space for B.
  assign reg_ready = !(reg_addr && (phase_q == PhB) && fifo_full);
  assign accept    = reg_valid && reg_ready;

`ifdef PALETTE_CTRL_ANYTIME_EN
  logic unused_blank;
  assign unused_blank = blank;
  assign pop = !fifo_empty;
`else
  assign pop = blank && !fifo_empty;
`endif

  // Phase state register
  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) phase_q <= PhR;
    else         phase_q <= phase_d;
  end

  // Phase next-state
  always_comb begin
    phase_d = phase_q;
    if (accept) begin
      if (!reg_addr) begin
        phase_d = PhR;
      end else begin
        unique case (phase_q)
          PhR:     phase_d = PhG;
          PhG:     phase_d = PhB;
          PhB:     phase_d = PhR;
          default: phase_d = PhR;
        endcase
      end
    end
  end

  // Phase decoded outputs
  always_comb begin
    ld_index = accept && !reg_addr;
    ld_r     = 1'b0;
    ld_g     = 1'b0;
    push     = 1'b0;
    if (accept && reg_addr) begin
      unique case (phase_q)
        PhR:     ld_r = 1'b1;
        PhG:     ld_g = 1'b1;
        PhB:     push = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      index_q <= '0;
      r_q     <= '0;
      g_q     <= '0;
    end else begin
      if (ld_index)  index_q <= reg_wdata;
      else if (push) index_q <= index_q + 8'd1;
      if (ld_r) r_q <= reg_wdata;
      if (ld_g) g_q <= reg_wdata;
    end
  end

  // Storage is not reset; the pointers and count define what is valid.
  always_ff @(posedge clk_pix) begin
    if (push) mem[wr_ptr_q] <= {index_q, r_q, g_q, reg_wdata};
  end

  assign head = mem[rd_ptr_q];

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      pal_we_q    <= 1'b0;
      pal_addr_q  <= '0;
      pal_wdata_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      busy_q   <= (count_d != '0) || (phase_d != PhR);
      pal_we_q <= pop;
      if (pop) begin
        pal_addr_q  <= head[31:24];
        pal_wdata_q <= head[23:0];
      end
    end
  end

  assign pal_we     = pal_we_q;
  assign pal_addr   = pal_addr_q;
  assign pal_wdata  = pal_wdata_q;
  assign fifo_level = count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_palette_ctrl.sv
// Directed bench for palette_ctrl with a scoreboard of expected palette writes.
module tb_palette_ctrl;

  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic          clk_pix = 1'b0;
  logic          rst_pix = 1'b1;
  logic          reg_valid = 1'b0;
  logic          reg_ready;
  logic          reg_addr = 1'b0;
  logic [7:0]    reg_wdata = '0;
  logic          blank = 1'b1;
  logic          pal_we;
  logic [7:0]    pal_addr;
  logic [23:0]   pal_wdata;
  logic [AW:0]   fifo_level;
  logic          busy;

  palette_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_pix    (clk_pix),
    .rst_pix    (rst_pix),
    .reg_valid  (reg_valid),
    .reg_ready  (reg_ready),
    .reg_addr   (reg_addr),
    .reg_wdata  (reg_wdata),
    .blank      (blank),
    .pal_we     (pal_we),
    .pal_addr   (pal_addr),
    .pal_wdata  (pal_wdata),
    .fifo_level (fifo_level),
    .busy       (busy)
  );

  always #5 clk_pix = ~clk_pix;

  int checks = 0;
  int failures = 0;
  int wr_cnt = 0;
  int max_level = 0;
  int base;
  logic [31:0] sb[$];
  logic [31:0] mon_exp;

  // Host-side model of the index/phase registers
  logic [7:0] m_idx = '0;
  logic [7:0] m_r = '0;
  logic [7:0] m_g = '0;
  int         m_ph = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic host_write(input logic a, input logic [7:0] d, input int budget);
    int n = 0;
    reg_valid = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    @(negedge clk_pix);
    while (!reg_ready && n < budget) begin
      @(negedge clk_pix);
      n++;
    end
    if (!reg_ready) begin
      chk("stall_timeout", 32'(reg_ready), 32'd1);
      reg_valid = 1'b0;
      return;
    end
    @(posedge clk_pix);
    if (!a) begin
      m_idx = d;
      m_ph  = 0;
    end else if (m_ph == 0) begin
      m_r  = d;
      m_ph = 1;
    end else if (m_ph == 1) begin
      m_g  = d;
      m_ph = 2;
    end else begin
      sb.push_back({m_idx, m_r, m_g, d});
      m_idx = m_idx + 8'd1;
      m_ph  = 0;
    end
    #1 reg_valid = 1'b0;
  endtask

  task automatic triple(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    host_write(1'b1, r, 50);
    host_write(1'b1, g, 50);
    host_write(1'b1, b, 50);
  endtask

  always @(negedge clk_pix) begin
    if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    if (pal_we === 1'b1) begin
      wr_cnt++;
      chk("we_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_exp = sb.pop_front();
        chk("commit", {pal_addr, pal_wdata}, mon_exp);
      end
    end
  end

  initial begin
    // Reset, idle
    repeat (3) @(posedge clk_pix);
    #1 rst_pix = 1'b0;
    repeat (4) @(posedge clk_pix);
    #1;
    chk("rst_we", 32'(pal_we), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(pal_addr), 32'd0);
    chk("rst_wdata", 32'(pal_wdata), 32'd0);
    chk("rst_ready", 32'(reg_ready), 32'd1);
    chk("rst_writes", 32'(wr_cnt), 32'd0);

    // Single entry
    blank = 1'b0;
    host_write(1'b0, 8'h10, 50);
    triple(8'hAA, 8'hBB, 8'hCC);
    repeat (2) @(posedge clk_pix);
    #1;
    chk("single_level", 32'(fifo_level), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_nowe", 32'(wr_cnt), 32'd0);
    blank = 1'b1;
    repeat (4) @(posedge clk_pix);
    #1;
    chk("single_writes", 32'(wr_cnt), 32'd1);
    chk("single_addr", 32'(pal_addr), 32'h10);
    chk("single_data", 32'(pal_wdata), 32'hAABBCC);
    chk("single_level0", 32'(fifo_level), 32'd0);
    chk("single_busy0", 32'(busy), 32'd0);

    // Auto-increment and wrap
    base = wr_cnt;
    host_write(1'b0, 8'hFE, 50);
    triple(8'h01, 8'h02, 8'h03);
    triple(8'h04, 8'h05, 8'h06);
    repeat (4) @(posedge clk_pix);
    #1;
    chk("wrap_addr_ff", 32'(pal_addr), 32'hFF);
    chk("wrap_data_ff", 32'(pal_wdata), 32'h040506);
    triple(8'h07, 8'h08, 8'h09);
    repeat (4) @(posedge clk_pix);
    #1;
    chk("wrap_addr_00", 32'(pal_addr), 32'h00);
    chk("wrap_data_00", 32'(pal_wdata), 32'h070809);
    chk("wrap_writes", 32'(wr_cnt - base), 32'd3);

    // Back-pressure: 16 entries fill the FIFO, the 17th B byte stalls
    blank = 1'b0;
    base = wr_cnt;
    max_level = 0;
    host_write(1'b0, 8'h40, 50);
    for (int i = 0; i < 16; i++) triple(8'(i), 8'(i + 8'h20), 8'(i + 8'h80));
    host_write(1'b1, 8'h5A, 50);
    host_write(1'b1, 8'h5B, 50);
    fork
      host_write(1'b1, 8'h5C, 50);
      begin
        repeat (6) @(negedge clk_pix);
        chk("bp_ready_low", 32'(reg_ready), 32'd0);
        chk("bp_level_full", 32'(fifo_level), 32'd16);
        chk("bp_no_commit", 32'(wr_cnt - base), 32'd0);
        blank = 1'b1;
      end
    join
    repeat (25) @(posedge clk_pix);
    #1;
    chk("bp_writes", 32'(wr_cnt - base), 32'd17);
    chk("bp_peak", 32'(max_level), 32'd16);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);
    chk("bp_last_addr", 32'(pal_addr), 32'h50);
    chk("bp_last_data", 32'(pal_wdata), 32'h5A5B5C);

    // Partial discard
    blank = 1'b0;
    base = wr_cnt;
    host_write(1'b0, 8'h20, 50);
    host_write(1'b1, 8'h11, 50);
    host_write(1'b1, 8'h22, 50);
    host_write(1'b0, 8'h30, 50);
    triple(8'h33, 8'h44, 8'h55);
    blank = 1'b1;
    repeat (4) @(posedge clk_pix);
    #1;
    chk("partial_writes", 32'(wr_cnt - base), 32'd1);
    chk("partial_addr", 32'(pal_addr), 32'h30);
    chk("partial_data", 32'(pal_wdata), 32'h334455);

    // Blank drop, then reset mid-burst
    blank = 1'b0;
    host_write(1'b0, 8'h80, 50);
    for (int i = 0; i < 4; i++) triple(8'(8'hC0 + i), 8'(8'hD0 + i), 8'(8'hE0 + i));
    base = wr_cnt;
    blank = 1'b1;
    @(posedge clk_pix);
    @(posedge clk_pix);
    #1 blank = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    chk("drop_writes", 32'(wr_cnt - base), 32'd2);
    chk("drop_level", 32'(fifo_level), 32'd2);
    chk("drop_busy", 32'(busy), 32'd1);
    rst_pix = 1'b1;
    sb.delete();
    m_idx = '0;
    m_ph  = 0;
    repeat (2) @(posedge clk_pix);
    #1;
    chk("mrst_level", 32'(fifo_level), 32'd0);
    chk("mrst_addr", 32'(pal_addr), 32'd0);
    chk("mrst_wdata", 32'(pal_wdata), 32'd0);
    rst_pix = 1'b0;
    blank = 1'b1;
    base = wr_cnt;
    repeat (6) @(posedge clk_pix);
    #1;
    chk("mrst_writes", 32'(wr_cnt - base), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
